// File: rtl/pcg32_pkg.sv
// Shared PCG32 constants, FSM state type and the xorshift output function
// used by the round-robin random-word server.
package pcg32_pkg;

    localparam logic [63:0] PCG32_MULT         = 64'h5851f42d4c957f2d;
    localparam logic [63:0] PCG32_INC          = 64'h14057b7ef767814f;
    localparam logic [63:0] PCG32_DEFAULT_SEED = 64'h123456789abcdef0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } fsm_e;

    function automatic logic [31:0] pcg32_out(input logic [63:0] state);
        return state[31:0] ^ (state[63:32] >> 18);
    endfunction

endpackage

// File: rtl/pcg32_core.sv
// PCG32 state register with seed load and single-step LCG advance;
// exposes the xorshift output of the current (pre-advance) state.
module pcg32_core
    import pcg32_pkg::*;
#(
    parameter logic [63:0] SEED = PCG32_DEFAULT_SEED,
    parameter logic [63:0] MULT = PCG32_MULT,
    parameter logic [63:0] INC  = PCG32_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        adv,
    output logic [63:0] state,
    output logic [31:0] out
);

    logic [63:0] state_q;
    logic [63:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_data;
        end else if (adv) begin
            // Product truncated to 64 bits; wrap-around is the intended modulus.
            state_d = state_q * MULT + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign out   = pcg32_out(state_q);

endmodule

// File: rtl/pcg32_rr_server.sv
// Round-robin server sharing one PCG32 generator among NREQ requesters.
// Optional per-requester saturating grant counters: define PCG32_RR_GRANT_CNT_EN.
module pcg32_rr_server
    import pcg32_pkg::*;
#(
    parameter int          NREQ = 4,
    parameter logic [63:0] SEED = 64'h123456789abcdef0,
    parameter logic [63:0] MULT = 64'h5851f42d4c957f2d,
    parameter logic [63:0] INC  = 64'h14057b7ef767814f
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [31:0]     rnd_data,
    output logic            rnd_valid,
    input  logic            seed_valid,
    input  logic [63:0]     seed_data,
    output logic            seed_ready,
    output logic            busy
`ifdef PCG32_RR_GRANT_CNT_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = LW + 2;

    fsm_e            fsm_q, fsm_d;
    logic [LW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [31:0]     rnd_data_q, rnd_data_d;
    logic            seed_load;
    logic            adv;
    logic [63:0]     core_state;
    logic [31:0]     core_out;
    logic [LW-1:0]   win;
    logic [IW-1:0]   scan_idx;
    logic            found;

    pcg32_core #(
        .SEED (SEED),
        .MULT (MULT),
        .INC  (INC)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (seed_load),
        .load_data (seed_data),
        .adv       (adv),
        .state     (core_state),
        .out       (core_out)
    );

    // Scan last+1, last+2, ... wrapping, so the previous winner is checked last.
    always_comb begin
        win      = last_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = IW'(last_q) + IW'(k);
            if (scan_idx >= IW'(NREQ)) begin
                scan_idx = scan_idx - IW'(NREQ);
            end
            if (!found && req[scan_idx[LW-1:0]]) begin
                found = 1'b1;
                win   = scan_idx[LW-1:0];
            end
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        last_d     = last_q;
        gnt_d      = '0;
        rnd_data_d = rnd_data_q;
        seed_load  = 1'b0;
        adv        = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (seed_valid) begin
                    seed_load = 1'b1;
                end else if (found) begin
                    last_d     = win;
                    gnt_d[win] = 1'b1;
                    rnd_data_d = core_out;
                    fsm_d      = GRANT;
                end
            end
            GRANT: begin
                // Word was captured from the pre-advance state on entry.
                adv   = 1'b1;
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            last_q     <= LW'(NREQ - 1);
            gnt_q      <= '0;
            rnd_data_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            rnd_data_q <= rnd_data_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_data   = rnd_data_q;
    assign rnd_valid  = |gnt_q;
    assign busy       = (fsm_q == GRANT);
    assign seed_ready = (fsm_q == IDLE);

`ifdef PCG32_RR_GRANT_CNT_EN
    logic [NREQ*16-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (seed_load) begin
            cnt_d = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q[i] && (cnt_q[16*i +: 16] != 16'hffff)) begin
                    cnt_d[16*i +: 16] = cnt_q[16*i +: 16] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`else
    logic unused_state;
    assign unused_state = ^core_state;
`endif

endmodule
